// File: rtl/impl_chk_pkg.sv
// -----------------------------------------------------------------------------
// impl_chk_pkg
// Shared types and helpers for the bounded implication checker.
//   ch_state_e : per-channel FSM state (IDLE / WAIT)
//   cnt_width  : width of a delay counter that must hold 0..max_dly
// -----------------------------------------------------------------------------
package impl_chk_pkg;

   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_WAIT = 1'b1
   } ch_state_e;

   function automatic int cnt_width(input int max_dly);
      if (max_dly < 1) begin
         return 1;
      end
      return $clog2(max_dly + 1);
   endfunction

endpackage

// File: rtl/impl_chk_channel.sv
// -----------------------------------------------------------------------------
// impl_chk_channel
// One channel of the bounded implication checker:
//   antecedent |-> ##[MIN_DLY:MAX_DLY] consequent
// Holds the channel FSM and its delay counter. Event outputs are combinational
// and describe what the current cycle resolves to; the top registers them.
//
// Ports:
//   clk          in   clock, posedge
//   rst_n        in   synchronous active-low reset
//   en           in   channel enable; low forces IDLE and drops the obligation
//   antecedent   in   trigger
//   consequent   in   response
//   pass_evt     out  obligation met this cycle
//   fail_evt     out  window expires this cycle without a consequent
//   overlap_evt  out  antecedent seen while an obligation is pending
//   arm          out  channel will be in WAIT next cycle
//   state        out  current FSM state (debug / checker binding)
// -----------------------------------------------------------------------------
module impl_chk_channel
   import impl_chk_pkg::*;
#(
   parameter int MIN_DLY = 1,
   parameter int MAX_DLY = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      en,
   input  logic      antecedent,
   input  logic      consequent,
   output logic      pass_evt,
   output logic      fail_evt,
   output logic      overlap_evt,
   output logic      arm,
   output ch_state_e state
);

   localparam int CW = cnt_width(MAX_DLY);

   ch_state_e       state_next;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_next;
   logic            met;
   logic            expired;

   // cnt holds the elapsed delay d of the current cycle while in WAIT.
   // A consequent before MIN_DLY is simply ignored, so expiry only needs
   // to look at the upper bound.
   assign met     = (state == CH_WAIT) && consequent && (int'(cnt) >= MIN_DLY);
   assign expired = (state == CH_WAIT) && !met && (int'(cnt) == MAX_DLY);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= CH_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      pass_evt    = 1'b0;
      fail_evt    = 1'b0;
      overlap_evt = 1'b0;
      if (!en) begin
         state_next = CH_IDLE;
         cnt_next   = '0;
      end else begin
         unique case (state)
            CH_IDLE: begin
               if (antecedent) begin
                  if ((MIN_DLY == 0) && consequent) begin
                     // zero-delay obligation satisfied immediately
                     pass_evt = 1'b1;
                  end else begin
                     state_next = CH_WAIT;
                     cnt_next   = CW'(1);
                  end
               end
            end
            CH_WAIT: begin
               if (met || expired) begin
                  pass_evt = met;
                  fail_evt = expired;
                  // an antecedent on the resolving cycle starts a fresh
                  // obligation back-to-back rather than counting as overlap
                  if (antecedent) begin
                     state_next = CH_WAIT;
                     cnt_next   = CW'(1);
                  end else begin
                     state_next = CH_IDLE;
                     cnt_next   = '0;
                  end
               end else begin
                  // only one obligation is tracked; a second trigger is flagged
                  overlap_evt = antecedent;
                  cnt_next    = cnt + CW'(1);
               end
            end
            default: begin
               state_next = CH_IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   assign arm = (state_next == CH_WAIT);

endmodule

// File: rtl/bounded_implication_checker.sv
// -----------------------------------------------------------------------------
// bounded_implication_checker
// Multi-channel synthesizable monitor for
//   antecedent |-> ##[MIN_DLY:MAX_DLY] consequent
// Each channel is an impl_chk_channel; this level registers all outputs,
// keeps the sticky error bits and the saturating fail counter.
//
// Optional feature: define BOUNDED_IMPL_SVA_EN to add concurrent assertions
// and cover properties. Ports and behaviour are identical either way.
//
// Ports:
//   clk            in   clock, posedge
//   rst_n          in   synchronous active-low reset
//   en             in   [NUM_CH] per-channel enable
//   antecedent     in   [NUM_CH] per-channel trigger
//   consequent     in   [NUM_CH] per-channel response
//   clear_err      in   clears err_sticky (a same-cycle fail wins)
//   busy           out  [NUM_CH] outstanding obligation, through resolve cycle
//   pass_pulse     out  [NUM_CH] obligation met
//   fail_pulse     out  [NUM_CH] window expired
//   overlap_pulse  out  [NUM_CH] antecedent while already waiting
//   err_sticky     out  [NUM_CH] latched failure
//   fail_count     out  [FCNT_W] total failures, saturating
// -----------------------------------------------------------------------------
module bounded_implication_checker
   import impl_chk_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int MIN_DLY = 1,
   parameter int MAX_DLY = 4,
   parameter int FCNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] en,
   input  logic [NUM_CH-1:0] antecedent,
   input  logic [NUM_CH-1:0] consequent,
   input  logic              clear_err,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] pass_pulse,
   output logic [NUM_CH-1:0] fail_pulse,
   output logic [NUM_CH-1:0] overlap_pulse,
   output logic [NUM_CH-1:0] err_sticky,
   output logic [FCNT_W-1:0] fail_count
);

   localparam int PC_W  = $clog2(NUM_CH + 1);
   // one bit of headroom so the add never wraps before saturation
   localparam int SUM_W = ((FCNT_W > PC_W) ? FCNT_W : PC_W) + 1;
   localparam logic [FCNT_W-1:0] FCNT_MAX = '1;

   if ((MAX_DLY < 1) || (MIN_DLY < 0) || (MAX_DLY < MIN_DLY)) begin : g_param_err
      $error("bounded_implication_checker: need MAX_DLY >= 1 and 0 <= MIN_DLY <= MAX_DLY");
   end

   logic [NUM_CH-1:0] pass_evt;
   logic [NUM_CH-1:0] fail_evt;
   logic [NUM_CH-1:0] overlap_evt;
   logic [NUM_CH-1:0] arm;
   logic [NUM_CH-1:0] busy_d;
   ch_state_e         ch_state [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      impl_chk_channel #(
         .MIN_DLY (MIN_DLY),
         .MAX_DLY (MAX_DLY)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .en          (en[i]),
         .antecedent  (antecedent[i]),
         .consequent  (consequent[i]),
         .pass_evt    (pass_evt[i]),
         .fail_evt    (fail_evt[i]),
         .overlap_evt (overlap_evt[i]),
         .arm         (arm[i]),
         .state       (ch_state[i])
      );
      // busy covers the waiting cycles and also the cycle in which the
      // resolving pulse is visible; dropping en clears it immediately
      assign busy_d[i] = arm[i] | (en[i] & (ch_state[i] == CH_WAIT));
   end

   logic [SUM_W-1:0]  fail_num;
   logic [SUM_W-1:0]  fail_sum;
   logic [FCNT_W-1:0] fail_count_next;

   always_comb begin
      fail_num = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         fail_num = fail_num + SUM_W'(fail_evt[i]);
      end
      fail_sum        = SUM_W'(fail_count) + fail_num;
      fail_count_next = (fail_sum > SUM_W'(FCNT_MAX)) ? FCNT_MAX : fail_sum[FCNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy          <= '0;
         pass_pulse    <= '0;
         fail_pulse    <= '0;
         overlap_pulse <= '0;
         err_sticky    <= '0;
         fail_count    <= '0;
      end else begin
         busy          <= busy_d;
         pass_pulse    <= pass_evt;
         fail_pulse    <= fail_evt;
         overlap_pulse <= overlap_evt;
         // set wins over clear in the same cycle
         err_sticky    <= (clear_err ? '0 : err_sticky) | fail_evt;
         fail_count    <= fail_count_next;
      end
   end

`ifdef BOUNDED_IMPL_SVA_EN
   default clocking cb @(posedge clk);
   endclocking

   for (genvar i = 0; i < NUM_CH; i++) begin : g_sva
      a_impl: assert property (disable iff (!rst_n || !en[i])
         antecedent[i] && !busy[i] |-> ##[MIN_DLY:MAX_DLY] consequent[i]);
      c_impl: cover property (disable iff (!rst_n || !en[i])
         antecedent[i] && !busy[i] ##[MIN_DLY:MAX_DLY] consequent[i]);
      a_excl: assert property (disable iff (!rst_n)
         !(pass_pulse[i] && fail_pulse[i]));
   end

   a_fcnt_mono: assert property (disable iff (!rst_n)
      fail_count >= $past(fail_count));
`else
`endif

endmodule

// File: doc/bounded_implication_checker.md
Name: bounded_implication_checker

Overview:
- Parametrised, multi-channel RTL checker for bounded implication: antecedent |-> ##[MIN_DLY:MAX_DLY] consequent.
- Generalises the single-cycle, single-channel overlapping-implication check to N independent channels with a delay window.
- Each channel runs a small FSM and reports pass/fail pulses, a sticky error, and an overlap flag. A saturating fail counter aggregates all channels.
- Instantiated alongside DUTs, or bound into them, as a synthesizable monitor that also works in formal.

Parameters:
- NUM_CH, 4, number of independent channels.
- MIN_DLY, 1, earliest cycle (after antecedent) at which a consequent satisfies; 0 allowed.
- MAX_DLY, 4, last cycle at which a consequent satisfies; must be >=1 and >=MIN_DLY, else elaboration $error.
- FCNT_W, 16, width of the saturating fail counter.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  reset, synchronous active-low.
- en  in  NUM_CH  per-channel enable.
- antecedent  in  NUM_CH  per-channel trigger.
- consequent  in  NUM_CH  per-channel response.
- clear_err  in  1  clears all err_sticky bits.
- busy  out  NUM_CH  channel has an outstanding obligation.
- pass_pulse  out  NUM_CH  one-cycle pulse, obligation met.
- fail_pulse  out  NUM_CH  one-cycle pulse, window expired.
- overlap_pulse  out  NUM_CH  one-cycle pulse, antecedent while busy.
- err_sticky  out  NUM_CH  latched failure per channel.
- fail_count  out  FCNT_W  total failures, saturating.

Behaviour:
- Timing: "cycle N" means a signal is sampled at the edge ending cycle N. Antecedent in cycle A gives elapsed delay d = C - A for a consequent in cycle C.
- All outputs are registered and appear in the cycle after the sampling edge.
- Reset (rst_n=0 at an edge): every channel goes to IDLE and its delay counter to 0. All outputs clear to 0, including err_sticky and fail_count. Reset mid-WAIT abandons the obligation silently, with no pulse.
- Channel FSM, IDLE:
  - en&&antecedent with MIN_DLY==0 and consequent in the same cycle: pass_pulse, stay IDLE.
  - en&&antecedent otherwise: go to WAIT, cnt=1 next cycle.
- Channel FSM, WAIT (busy=1), cnt = d of the current cycle:
  - consequent with cnt>=MIN_DLY: pass, go to IDLE.
  - consequent with cnt<MIN_DLY: ignored (SVA ##[m:n] semantics).
  - cnt==MAX_DLY and no consequent: fail, go to IDLE.
  - otherwise cnt++.
- Antecedent in WAIT on a non-resolving cycle: overlap_pulse; the obligation is not tracked (single outstanding per channel).
- Antecedent on the resolving cycle: channel re-arms straight into WAIT with cnt=1 (back-to-back), no overlap.
- en low: channel forced to IDLE next edge; an in-flight obligation is dropped with no pulse; inputs ignored.
- err_sticky[i] sets on fail. Set has priority over clear_err in the same cycle.
- fail_count adds popcount(fail events this cycle) and saturates at 2^FCNT_W-1. clear_err does not affect it.
- Counter width is $clog2(MAX_DLY+1).

Optional Feature:
- Macro BOUNDED_IMPL_SVA_EN. Defined, it adds per-channel concurrent SVA under default clocking @(posedge clk), disable iff (!rst_n || !en[i]):
  - assert property (antecedent[i] && !busy[i] |-> ##[MIN_DLY:MAX_DLY] consequent[i]);
  - cover property of the same sequence, so pass traces are generated;
  - assert that fail_pulse and pass_pulse are never both high;
  - assert that fail_count never decreases except at reset.
- Undefined: pure RTL, identical ports and behaviour, no assertions.

Decomposition:
- Package impl_chk_pkg: typedef enum logic {CH_IDLE, CH_WAIT} ch_state_e; function cnt_width(max_dly).
- Sub-module impl_chk_channel: one FSM and delay counter per channel, generated NUM_CH times.
- Top level: fail popcount, saturating counter, sticky logic, optional SVA.

Test Plan (NUM_CH=4, MIN_DLY=1, MAX_DLY=4 unless noted):
- Reset: rst_n=0 for cycles 5-7 while ch0 in WAIT -> cycle 8: busy=0, all pulses 0, err_sticky=0, fail_count=0, no pass/fail ever reported for that obligation.
- Pass: ch0 antecedent cycle 10, consequent cycle 12 -> pass_pulse[0]=1 in cycle 13 only; busy[0] high cycles 11-13, low cycle 14.
- Fail and overlap: ch1 antecedent cycle 20, consequent only cycle 20 (d=0, ignored), antecedent again cycle 21 ->
  - overlap_pulse[1] in cycle 22;
  - fail_pulse[1] in cycle 25;
  - err_sticky[1]=1 from cycle 25;
  - fail_count=1.
- Simultaneous fails: all 4 channels antecedent cycle 30, no consequent -> fail_pulse=4'hF in cycle 35, fail_count +=4. With FCNT_W=3, 9 single fails -> fail_count=7, held.
- Clear vs set and re-arm: clear_err in cycle 34 (the ch2 resolving cycle) -> err_sticky[2] stays 1. ch0 antecedent cycle 40, consequent+antecedent cycle 42, consequent cycle 45 -> pass_pulse[0] in cycles 43 and 46, no overlap.
- MIN_DLY=0 build: antecedent and consequent both in cycle 50 -> pass_pulse in cycle 51, busy never set. With BOUNDED_IMPL_SVA_EN, the cover hits and no assertion fires across the whole test.
